// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder, LSB-first: oversamples sclk/cs/mosi in the clk domain,
// deserialises BITS-bit frames to rx_data and returns a preloaded word on miso.
module spi_slave_rx #(
  parameter int BITS    = 12,
  parameter int SYNC_FF = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sclk,
  input  logic            cs,
  input  logic            mosi,
  output logic            miso,
  input  logic [BITS-1:0] tx_data,
  input  logic            tx_load,
  output logic [BITS-1:0] rx_data,
  output logic            rx_valid,
  output logic            busy,
  output logic            frame_err
);
  localparam int CW = $clog2(BITS + 1);
  localparam int IW = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_FF-1:0] sclk_ff, cs_ff, mosi_ff, fill;
  logic               sclk_s, cs_s, mosi_s, sclk_q;
  logic               sclk_rise, sclk_fall;
  logic               armed, pend;
  state_t             state;
  logic [CW-1:0]      bit_cnt;
  logic [BITS-1:0]    shadow, shadow_nxt, tx_shift, rx_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_ff <= '0;
      cs_ff   <= '1;
      mosi_ff <= '0;
      fill    <= '0;
      sclk_q  <= 1'b0;
    end else begin
      sclk_ff <= {sclk_ff[SYNC_FF-2:0], sclk};
      cs_ff   <= {cs_ff[SYNC_FF-2:0], cs};
      mosi_ff <= {mosi_ff[SYNC_FF-2:0], mosi};
      fill    <= {fill[SYNC_FF-2:0], 1'b1};
      sclk_q  <= sclk_s;
    end
  end

  assign sclk_s     = sclk_ff[SYNC_FF-1];
  assign cs_s       = cs_ff[SYNC_FF-1];
  assign mosi_s     = mosi_ff[SYNC_FF-1];
  assign sclk_rise  = sclk_s & ~sclk_q;
  assign sclk_fall  = ~sclk_s & sclk_q;
  // A load coinciding with frame start must reach that frame.
  assign shadow_nxt = tx_load ? tx_data : shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shadow    <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      miso      <= 1'b0;
      armed     <= 1'b0;
      pend      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      shadow    <= shadow_nxt;
      // A frame may only start after cs has been genuinely seen high since
      // reset, so a cs held low across reset never opens a frame.
      if (fill[SYNC_FF-1] && cs_s) armed <= 1'b1;
      if (pend) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        pend     <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (armed && !cs_s) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            tx_shift <= shadow_nxt;
            miso     <= shadow_nxt[0];
            busy     <= 1'b1;
            armed    <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            // cs release outranks a same-cycle sclk rise; that bit is dropped.
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            miso      <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift[bit_cnt[IW-1:0]] <= mosi_s;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(BITS - 1)) begin
              state <= DONE;
              pend  <= 1'b1;
            end
          end else if (sclk_fall) begin
            tx_shift <= tx_shift >> 1;
            miso     <= tx_shift[1];
          end
        end
        DONE: begin
          if (cs_s) begin
            state <= IDLE;
            busy  <= 1'b0;
            miso  <= 1'b0;
          end else if (sclk_fall) begin
            miso <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a bit-banged mode-0 master at clk/8 with
// hand-computed expected rx words, miso words and pulse counts.
module tb_spi_slave_rx;
  logic        clk = 0, rst = 1, sclk = 0, cs = 1, mosi = 0, tx_load = 0;
  logic [11:0] tx_data = '0;
  logic        miso, rx_valid, busy, frame_err;
  logic [11:0] rx_data;
  logic [11:0] mb;
  int nvec = 0, nmis = 0;
  int nv = 0, ne = 0, nboth = 0;
  int v0, e0;

  spi_slave_rx #(.BITS(12), .SYNC_FF(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid) nv++;
    if (frame_err) ne++;
    if (rx_valid && frame_err) nboth++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] v);
    tx_data = v; tx_load = 1; cyc(1); tx_load = 0;
  endtask

  // Master frame: n sclk pulses with data d; optionally pulse tx_load at bit
  // ld_at; optionally leave cs low afterwards. Returns sampled miso bits.
  task automatic frame(input logic [15:0] d, input int n, input bit hold,
                       input int ld_at, input logic [11:0] ld_val,
                       output logic [11:0] bits);
    bits = '0;
    cs = 0; mosi = d[0];
    cyc(6);
    chk("busy_in_frame", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (i < 12) bits[i] = miso;
      sclk = 1; cyc(4);
      sclk = 0; mosi = (i + 1 < 16) ? d[i+1] : 1'b0;
      if (i == ld_at) begin
        tx_data = ld_val; tx_load = 1; cyc(1); tx_load = 0; cyc(3);
      end else cyc(4);
    end
    if (!hold) begin
      cs = 1; cyc(3);
      chk("busy_after_cs", busy, 0);
      chk("miso_cs_high", miso, 0);
      cyc(1);
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_miso", miso, 0);
    rst = 0; cyc(4);

    // 1: basic frame
    load(12'hA5C); cyc(2);
    v0 = nv; e0 = ne;
    frame(16'h03C7, 12, 0, -1, 0, mb); cyc(4);
    chk("t1_rx_data", rx_data, 12'h3C7);
    chk("t1_valid_cnt", nv - v0, 1);
    chk("t1_miso", mb, 12'hA5C);

    // 2: back-to-back, cs high 4 clk between frames
    v0 = nv;
    frame(16'h0FFF, 12, 0, -1, 0, mb);
    chk("t2_miso_a", mb, 12'hA5C);
    frame(16'h0001, 12, 0, -1, 0, mb); cyc(4);
    chk("t2_miso_b", mb, 12'hA5C);
    chk("t2_valid_cnt", nv - v0, 2);
    chk("t2_rx_data", rx_data, 12'h001);

    // 3: short frame
    v0 = nv; e0 = ne;
    frame(16'h00AB, 7, 0, -1, 0, mb); cyc(4);
    chk("t3_err_cnt", ne - e0, 1);
    chk("t3_valid_cnt", nv - v0, 0);
    chk("t3_rx_data", rx_data, 12'h001);

    // 4: 14 pulses, extras ignored
    v0 = nv; e0 = ne;
    frame(16'h3555, 14, 0, -1, 0, mb); cyc(4);
    chk("t4_rx_data", rx_data, 12'h555);
    chk("t4_valid_cnt", nv - v0, 1);
    chk("t4_err_cnt", ne - e0, 0);

    // 5: reset mid-frame with cs held low
    v0 = nv; e0 = ne;
    frame(16'h0FFF, 5, 1, -1, 0, mb);
    rst = 1; cyc(2); rst = 0; cyc(10);
    chk("t5_busy_after_rst", busy, 0);
    chk("t5_rx_data_rst", rx_data, 0);
    cs = 1; cyc(8);
    chk("t5_err_cnt", ne - e0, 0);
    chk("t5_valid_cnt", nv - v0, 0);
    frame(16'h00F0, 12, 0, -1, 0, mb); cyc(4);
    chk("t5_rx_data", rx_data, 12'h0F0);
    chk("t5_miso", mb, 12'h000);

    // 6: tx_load mid-frame only affects the next frame
    load(12'h456); cyc(2);
    frame(16'h02AA, 12, 0, 5, 12'h123, mb);
    chk("t6_miso_a", mb, 12'h456);
    frame(16'h0C33, 12, 0, -1, 0, mb); cyc(4);
    chk("t6_miso_b", mb, 12'h123);
    chk("t6_rx_data", rx_data, 12'hC33);

    chk("valid_err_overlap", nboth, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
